// File: rtl/pac_motion.sv
// Pac-Man sprite motion: latches direction requests and, on each movement tick,
// probes the wall map along the leading edge before stepping the sprite.
module pac_motion #(
    parameter int START_X = 304,
    parameter int START_Y = 224,
    parameter int SPRITE  = 32,
    parameter int STEP    = 1,
    parameter int X_MAX   = 608,
    parameter int Y_MAX   = 448
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick,
    input  logic [1:0] dir_req,
    input  logic       dir_req_valid,
    output logic [9:0] probe_x,
    output logic [8:0] probe_y,
    input  logic       probe_wall,
    output logic [9:0] PacX,
    output logic [8:0] PacY,
    output logic [1:0] state,
    output logic       moving,
    output logic       busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ_A = 3'd1;
    localparam logic [2:0] S_REQ_B = 3'd2;
    localparam logic [2:0] S_CUR_A = 3'd3;
    localparam logic [2:0] S_CUR_B = 3'd4;
    localparam logic [2:0] S_MOVE  = 3'd5;

    localparam logic signed [10:0] STEP_X = 11'(STEP);
    localparam logic signed [9:0]  STEP_Y = 10'(STEP);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [9:0]  YMAX_S = 10'(Y_MAX);
    localparam logic [9:0]         EX     = 10'(SPRITE - 1);
    localparam logic [8:0]         EY     = 9'(SPRITE - 1);

    // Candidates carry a sign bit so a step past the left/top edge reads as negative.
    function automatic logic signed [10:0] cand_x(input logic [1:0] d, input logic [9:0] x);
        logic signed [10:0] sx;
        sx = $signed({1'b0, x});
        case (d)
            2'b00:   cand_x = sx + STEP_X;
            2'b01:   cand_x = sx - STEP_X;
            default: cand_x = sx;
        endcase
    endfunction

    function automatic logic signed [9:0] cand_y(input logic [1:0] d, input logic [8:0] y);
        logic signed [9:0] sy;
        sy = $signed({1'b0, y});
        case (d)
            2'b10:   cand_y = sy + STEP_Y;
            2'b11:   cand_y = sy - STEP_Y;
            default: cand_y = sy;
        endcase
    endfunction

    function automatic logic in_bounds(input logic signed [10:0] cx, input logic signed [9:0] cy);
        in_bounds = (cx >= 11'sd0) && (cx <= XMAX_S) && (cy >= 10'sd0) && (cy <= YMAX_S);
    endfunction

    function automatic logic [18:0] probe_pt(input logic [1:0] d, input logic second,
                                             input logic signed [10:0] cx,
                                             input logic signed [9:0] cy);
        logic [9:0] ox;
        logic [8:0] oy;
        case (d)
            2'b00:   begin ox = EX;                oy = second ? EY : 9'd0; end
            2'b01:   begin ox = 10'd0;             oy = second ? EY : 9'd0; end
            2'b10:   begin ox = second ? EX : 10'd0; oy = EY;              end
            default: begin ox = second ? EX : 10'd0; oy = 9'd0;           end
        endcase
        probe_pt = {cx[9:0] + ox, cy[8:0] + oy};
    endfunction

    logic [2:0]  r_fsm;
    logic [9:0]  r_pac_x;
    logic [8:0]  r_pac_y;
    logic [1:0]  r_state;
    logic [1:0]  r_pdir;
    logic [1:0]  r_chk;
    logic        r_pend;
    logic        r_moving;
    logic        r_busy;
    logic [9:0]  r_probe_x;
    logic [8:0]  r_probe_y;

    logic              w_pend_eff;
    logic [1:0]        w_req_dir;
    logic signed [10:0] w_req_cx, w_cur_cx;
    logic signed [9:0]  w_req_cy, w_cur_cy;
    logic              w_req_ok, w_cur_ok, w_go_cur;
    logic [18:0]       w_req_p1, w_req_p2, w_cur_p1, w_cur_p2;

    // In IDLE a request arriving with the tick is already in effect for that tick.
    always_comb begin
        w_pend_eff = dir_req_valid ? (dir_req != r_state) : r_pend;
        w_req_dir  = (r_fsm == S_IDLE) ? (dir_req_valid ? dir_req : r_pdir) : r_chk;
        w_req_cx   = cand_x(w_req_dir, r_pac_x);
        w_req_cy   = cand_y(w_req_dir, r_pac_y);
        w_cur_cx   = cand_x(r_state, r_pac_x);
        w_cur_cy   = cand_y(r_state, r_pac_y);
        w_req_ok   = in_bounds(w_req_cx, w_req_cy);
        w_cur_ok   = in_bounds(w_cur_cx, w_cur_cy);
        w_req_p1   = probe_pt(w_req_dir, 1'b0, w_req_cx, w_req_cy);
        w_req_p2   = probe_pt(w_req_dir, 1'b1, w_req_cx, w_req_cy);
        w_cur_p1   = probe_pt(r_state, 1'b0, w_cur_cx, w_cur_cy);
        w_cur_p2   = probe_pt(r_state, 1'b1, w_cur_cx, w_cur_cy);
        w_go_cur   = 1'b0;
        case (r_fsm)
            S_IDLE:           w_go_cur = tick && !(w_pend_eff && w_req_ok);
            S_REQ_A, S_REQ_B: w_go_cur = probe_wall;
            default:          w_go_cur = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_fsm     <= S_IDLE;
            r_pac_x   <= 10'(START_X);
            r_pac_y   <= 9'(START_Y);
            r_state   <= 2'b00;
            r_pdir    <= 2'b00;
            r_chk     <= 2'b00;
            r_pend    <= 1'b0;
            r_moving  <= 1'b0;
            r_busy    <= 1'b0;
            r_probe_x <= 10'd0;
            r_probe_y <= 9'd0;
        end else begin
            if (dir_req_valid) begin
                r_pdir <= dir_req;
                r_pend <= (dir_req != r_state);
            end
            // Falling back to the current heading; an out-of-range candidate ends the tick.
            if (w_go_cur) begin
                if (w_cur_ok) begin
                    {r_probe_x, r_probe_y} <= w_cur_p1;
                    r_fsm  <= S_CUR_A;
                    r_busy <= 1'b1;
                end else begin
                    r_moving <= 1'b0;
                    r_fsm    <= S_IDLE;
                    r_busy   <= 1'b0;
                end
            end else begin
                case (r_fsm)
                    S_IDLE: if (tick) begin
                        r_chk <= w_req_dir;
                        {r_probe_x, r_probe_y} <= w_req_p1;
                        r_fsm  <= S_REQ_A;
                        r_busy <= 1'b1;
                    end
                    S_REQ_A: begin
                        {r_probe_x, r_probe_y} <= w_req_p2;
                        r_fsm <= S_REQ_B;
                    end
                    S_REQ_B: begin
                        r_state <= r_chk;
                        if (!dir_req_valid) r_pend <= 1'b0;
                        r_fsm <= S_MOVE;
                    end
                    S_CUR_A, S_CUR_B: begin
                        if (probe_wall) begin
                            r_moving <= 1'b0;
                            r_fsm    <= S_IDLE;
                            r_busy   <= 1'b0;
                        end else if (r_fsm == S_CUR_A) begin
                            {r_probe_x, r_probe_y} <= w_cur_p2;
                            r_fsm <= S_CUR_B;
                        end else begin
                            r_fsm <= S_MOVE;
                        end
                    end
                    S_MOVE: begin
                        r_pac_x  <= w_cur_cx[9:0];
                        r_pac_y  <= w_cur_cy[8:0];
                        r_moving <= 1'b1;
                        r_fsm    <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                    default: begin
                        r_fsm  <= S_IDLE;
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign probe_x = r_probe_x;
    assign probe_y = r_probe_y;
    assign PacX    = r_pac_x;
    assign PacY    = r_pac_y;
    assign state   = r_state;
    assign moving  = r_moving;
    assign busy    = r_busy;
endmodule

// File: tb/tb_pac_motion.sv
// Bench for pac_motion: directed vector table, corner sequences, and a randomized
// walk over a random tile map checked against a rule-level reference model.
module tb_pac_motion;
    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       dir_req_valid = 1'b0;
    logic [9:0] probe_x;
    logic [8:0] probe_y;
    logic       probe_wall;
    logic [9:0] PacX;
    logic [8:0] PacY;
    logic [1:0] state;
    logic       moving, busy;

    logic       e_tick = 1'b0;
    logic [1:0] e_dr = 2'b00;
    logic       e_dv = 1'b0;
    logic       e_wall = 1'b0;
    logic [9:0] e_px, e_x;
    logic [8:0] e_py, e_y;
    logic [1:0] e_s;
    logic       e_m, e_b;

    int n_chk = 0;
    int n_err = 0;
    int mode = 0;
    int e_bad_cnt = 0;
    bit wallmap [20][15];

    always #5 clk = ~clk;

    pac_motion u_dut (
        .clk(clk), .clrn(clrn), .tick(tick), .dir_req(dir_req), .dir_req_valid(dir_req_valid),
        .probe_x(probe_x), .probe_y(probe_y), .probe_wall(probe_wall),
        .PacX(PacX), .PacY(PacY), .state(state), .moving(moving), .busy(busy)
    );

    pac_motion #(.START_X(0)) u_edge (
        .clk(clk), .clrn(clrn), .tick(e_tick), .dir_req(e_dr), .dir_req_valid(e_dv),
        .probe_x(e_px), .probe_y(e_py), .probe_wall(e_wall),
        .PacX(e_x), .PacY(e_y), .state(e_s), .moving(e_m), .busy(e_b)
    );

    function automatic bit wall_at(input int md, input int px, input int py);
        case (md)
            1:       return px >= 336;
            2:       return py < 224;
            3:       return (px < 640 && py < 480) ? wallmap[px/32][py/32] : 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb probe_wall = wall_at(mode, int'(probe_x), int'(probe_y));

    // A probe column past the screen would mean a wrapped negative coordinate.
    always @(negedge clk) if (e_px > 10'd639) e_bad_cnt <= e_bad_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check();
        clrn = 1'b0;
        #2;
        chk("rst_x", int'(PacX), 304);
        chk("rst_y", int'(PacY), 224);
        chk("rst_state", int'(state), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_probe", int'({probe_x, probe_y}), 0);
        cyc();
        clrn = 1'b1;
        cyc();
    endtask

    task automatic run_tick(input bit rv, input logic [1:0] rd, input bit lv,
                            input logic [1:0] ld, output int bcnt);
        tick = 1'b1; dir_req_valid = rv; dir_req = rd;
        cyc();
        tick = 1'b0; dir_req_valid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (busy) bcnt++;
            cyc();
        end
        dir_req_valid = lv; dir_req = ld;
        cyc();
        dir_req_valid = 1'b0;
        cyc();
    endtask

    task automatic e_run(input bit rv, input logic [1:0] rd);
        e_tick = 1'b1; e_dv = rv; e_dr = rd;
        cyc();
        e_tick = 1'b0; e_dv = 1'b0;
        repeat (9) cyc();
    endtask

    // Reference model: sprite rectangle, blocked if off-screen or its leading edge ends hit a wall.
    int  mx, my, ms, mm, mpd;
    bit  mp;

    function automatic bit m_blocked(input int d);
        int cx, cy, e;
        e  = 31;
        cx = mx + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
        cy = my + ((d == 2) ? 1 : (d == 3) ? -1 : 0);
        if (cx < 0 || cx > 608 || cy < 0 || cy > 448) return 1'b1;
        case (d)
            0:       return wall_at(3, cx + e, cy) || wall_at(3, cx + e, cy + e);
            1:       return wall_at(3, cx, cy) || wall_at(3, cx, cy + e);
            2:       return wall_at(3, cx, cy + e) || wall_at(3, cx + e, cy + e);
            default: return wall_at(3, cx, cy) || wall_at(3, cx + e, cy);
        endcase
    endfunction

    task automatic m_req(input int d);
        mpd = d;
        mp  = (d != ms);
    endtask

    task automatic m_tick();
        bit go;
        go = 1'b0;
        if (mp && !m_blocked(mpd)) begin
            ms = mpd; mp = 1'b0; go = 1'b1;
        end else if (!m_blocked(ms)) begin
            go = 1'b1;
        end
        if (go) begin
            case (ms)
                0: mx++;
                1: mx--;
                2: my++;
                default: my--;
            endcase
        end
        mm = go ? 1 : 0;
    endtask

    typedef struct {
        bit         rst;
        bit         rv;
        logic [1:0] rd;
        int         md;
        int         ex, ey, es, em, bmax;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int bc;
        tbl[0] = '{1'b0, 1'b0, 2'd0, 0, 305, 224, 0, 1, 6};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 0, 306, 224, 0, 1, 6};
        tbl[2] = '{1'b0, 1'b0, 2'd0, 0, 307, 224, 0, 1, 6};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 1, 304, 224, 0, 0, 4};
        tbl[4] = '{1'b0, 1'b1, 2'd3, 2, 305, 224, 0, 1, 6};
        tbl[5] = '{1'b0, 1'b0, 2'd0, 2, 306, 224, 0, 1, 6};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 0, 306, 223, 3, 1, 6};
        tbl[7] = '{1'b0, 1'b1, 2'd2, 0, 306, 224, 2, 1, 6};
        for (int i = 0; i < 20; i++)
            for (int j = 0; j < 15; j++)
                wallmap[i][j] = ($urandom_range(0, 5) == 0);

        #1;
        reset_check();

        // Left screen edge on the START_X=0 instance.
        e_run(1'b0, 2'd0);
        chk("edge_x1", int'(e_x), 1);
        e_run(1'b1, 2'd1);
        chk("edge_x0", int'(e_x), 0);
        chk("edge_state", int'(e_s), 1);
        chk("edge_probe_y", int'(e_py), 255);
        e_run(1'b0, 2'd0);
        chk("edge_blk_x", int'(e_x), 0);
        chk("edge_blk_moving", int'(e_m), 0);
        chk("edge_blk_state", int'(e_s), 1);
        chk("edge_no_probe_x", int'(e_px), 0);
        chk("edge_no_probe_y", int'(e_py), 255);
        chk("edge_busy", int'(e_b), 0);
        chk("edge_wrap_probes", e_bad_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) reset_check();
            mode = tbl[i].md;
            run_tick(tbl[i].rv, tbl[i].rd, 1'b0, 2'd0, bc);
            chk($sformatf("vec%0d_x", i), int'(PacX), tbl[i].ex);
            chk($sformatf("vec%0d_y", i), int'(PacY), tbl[i].ey);
            chk($sformatf("vec%0d_state", i), int'(state), tbl[i].es);
            chk($sformatf("vec%0d_moving", i), int'(moving), tbl[i].em);
            chk($sformatf("vec%0d_busy_end", i), int'(busy), 0);
            chk($sformatf("vec%0d_busy_len", i), int'(bc >= 1 && bc <= tbl[i].bmax), 1);
        end

        // Second tick while busy must not add a step.
        mode = 0;
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        chk("dbl_busy_mid", int'(busy), 1);
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (12) cyc();
        chk("dbl_y", int'(PacY), 225);
        chk("dbl_x", int'(PacX), 306);
        chk("dbl_moving", int'(moving), 1);

        // Randomized walk on a random tile map.
        reset_check();
        mode = 3;
        mx = 304; my = 224; ms = 0; mm = 0; mp = 1'b0; mpd = 0;
        for (int k = 0; k < 200; k++) begin
            bit rv, lv;
            logic [1:0] rd, ld;
            rv = ($urandom_range(0, 3) == 0);
            lv = ($urandom_range(0, 3) == 0);
            rd = 2'($urandom_range(0, 3));
            ld = 2'($urandom_range(0, 3));
            run_tick(rv, rd, lv, ld, bc);
            if (rv) m_req(int'(rd));
            m_tick();
            chk($sformatf("rnd%0d_x", k), int'(PacX), mx);
            chk($sformatf("rnd%0d_y", k), int'(PacY), my);
            chk($sformatf("rnd%0d_state", k), int'(state), ms);
            chk($sformatf("rnd%0d_moving", k), int'(moving), mm);
            chk($sformatf("rnd%0d_busy", k), int'(busy), 0);
            if (lv) m_req(int'(ld));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pac_motion.md
Name: pac_motion

Overview:
- Produces Pac-Man's sprite position (PacX, PacY) and facing code (state), which the display renderer consumes once per frame.
- On each movement tick it applies any pending direction request and steps the sprite by STEP pixels, but only if the wall map reports no wall on the sprite's leading edge.
- Wall checks go through a probe interface to the combinational map lookup, one point per cycle.

Parameters:
- START_X, 304: reset X position (left edge, pixels)
- START_Y, 224: reset Y position (top edge, pixels)
- SPRITE, 32: sprite width and height in pixels
- STEP, 1: pixels moved per tick
- X_MAX, 608: largest legal PacX (640-SPRITE)
- Y_MAX, 448: largest legal PacY (480-SPRITE)

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle movement strobe (frame rate)
- dir_req  in  2  requested direction, same encoding as state
- dir_req_valid  in  1  one-cycle strobe; latches dir_req
- probe_x  out  10  map probe column
- probe_y  out  9  map probe row
- probe_wall  in  1  combinational map result for probe_x/probe_y, same cycle
- PacX  out  10  sprite left edge
- PacY  out  9  sprite top edge
- state  out  2  facing: 00 right, 01 left, 10 down, 11 up
- moving  out  1  1 if the last tick produced a step
- busy  out  1  1 while the FSM is not in IDLE

Behaviour:
- Reset (clrn=0, async): PacX=START_X, PacY=START_Y, state=00, moving=0, busy=0, pending request cleared, probe_x=0, probe_y=0, FSM=IDLE. All outputs are registered.
- Request latch: dir_req_valid=1 stores dir_req as the pending request and sets pend=1. A later request overwrites it. A request equal to state sets pend=0.
- FSM states: IDLE, REQ_A, REQ_B, CUR_A, CUR_B, MOVE.
- IDLE: on tick go to REQ_A if pend=1, otherwise CUR_A. A tick arriving while busy=1 is ignored. A dir_req_valid in the same cycle as tick is latched first and used for that tick.
- Candidate position for direction d: (PacX±STEP, PacY) or (PacX, PacY±STEP).
- Bounds check: a candidate below 0 or above X_MAX/Y_MAX is blocked. No probes are issued for it; the FSM skips to the next check.
- Probe points (cx,cy = candidate; E = SPRITE-1):
  - right: (cx+E,cy), (cx+E,cy+E)
  - left: (cx,cy), (cx,cy+E)
  - down: (cx,cy+E), (cx+E,cy+E)
  - up: (cx,cy), (cx+E,cy)
- *_A drives point 1 and *_B drives point 2, registered on entry to the state. probe_wall is sampled in that state. probe_wall=1 in either point blocks that direction.
- REQ_A/REQ_B check the pending direction.
  - Both clear: state<=pend dir, pend<=0, go to MOVE.
  - Either blocked: go to CUR_A. pend stays 1.
- CUR_A/CUR_B check the current state direction.
  - Both clear: go to MOVE.
  - Either blocked: moving<=0, return to IDLE with no position change.
- MOVE: PacX/PacY <= chosen candidate, moving<=1, go to IDLE.
- Latency: position updates at most 6 cycles after the tick cycle. The tick period must be at least 8 cycles.
- Arithmetic: compute candidates in 11/10-bit signed width so that underflow is detected, not wrapped.

Test Plan:
- Reset: assert clrn=0 mid-run → PacX=304, PacY=224, state=00, moving=0, busy=0 immediately, without waiting for a clock edge.
- Open field: probe_wall tied 0, 3 ticks spaced 10 cycles → PacX 304→305→306→307, PacY=224, moving=1 after the first step.
- Right wall: probe_wall=1 when probe_x≥336 → first tick blocked (probe at 304+1+31=336), PacX stays 304, moving=0, busy returns to 0 within 4 cycles.
- Deferred turn: wall when probe_y<224, request UP while heading right → PacX keeps incrementing, state=00, pend held. Clear the wall → next tick gives state=11, PacY=223.
- Left boundary: PacX=0 (START_X=0 build), state=01, tick → no probe asserted for x<0, PacX=0, moving=0.
- Simultaneous events: dir_req_valid=1 with dir_req=10 in the same cycle as tick, open map → that tick gives state=10, PacY=225. A second tick during busy=1 causes no extra step.
